// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_pkg : shared state, owner and beat constants
// Rev 1.0
// ============================================================================
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] c_last_beat    = 2'(BYTES_PER_WORD - 1);

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_if : processor fetch/load-store ports and byte memory bus
// Rev 1.0
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 5
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;
    logic              dm_err;

    logic              cpu_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, dm_err, cpu_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, dm_err, cpu_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter_mem_beat_seq.sv
`default_nettype none
// ============================================================================
// mem_beat_seq : issues four big-endian byte beats and assembles the read word
// Rev 1.0
// ============================================================================
module mem_beat_seq
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-3:0] base,
    input  wire logic              we,
    input  wire logic [31:0]       wdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_wdata,
    input  wire logic [7:0]        mem_rdata,
    output logic                   last,
    output logic [31:0]            word,
    output logic                   valid
);

    logic [ADDR_W-3:0] r_base;
    logic [1:0]        r_beat;
    logic              r_en;
    logic              r_we;
    logic [7:0]        r_wbyte;
    logic [23:0]       r_wsh;
    logic              r_cap;
    logic              r_cap_last;
    logic [23:0]       r_asm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_beat     <= 2'd0;
            r_en       <= 1'b0;
            r_we       <= 1'b0;
            r_wbyte    <= 8'h00;
            r_wsh      <= 24'h0;
            r_cap      <= 1'b0;
            r_cap_last <= 1'b0;
            r_asm      <= 24'h0;
        end else begin
            // Memory returns a byte one cycle after each beat
            r_cap      <= r_en;
            r_cap_last <= r_en && (r_beat == c_last_beat);
            if (r_cap) begin
                r_asm <= {r_asm[15:0], mem_rdata};
            end

            if (start) begin
                r_en    <= 1'b1;
                r_we    <= we;
                r_base  <= base;
                r_beat  <= 2'd0;
                r_wbyte <= wdata[31:24];
                r_wsh   <= wdata[23:0];
            end else if (r_en) begin
                if (r_beat == c_last_beat) begin
                    r_en <= 1'b0;
                    r_we <= 1'b0;
                end else begin
                    r_beat  <= r_beat + 2'd1;
                    r_wbyte <= r_wsh[23:16];
                    r_wsh   <= {r_wsh[15:0], 8'h00};
                end
            end
        end
    end

    assign mem_en    = r_en;
    assign mem_we    = r_we;
    assign mem_addr  = {r_base, r_beat};
    assign mem_wdata = r_wbyte;
    assign last      = r_en && (r_beat == c_last_beat);
    // Final byte is taken straight from the memory so the word is ready with ack
    assign word      = {r_asm, mem_rdata};
    assign valid     = r_cap_last;

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter : arbitrates fetch and load/store onto one byte memory
// Rev 1.0
// ============================================================================
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter bit DATA_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    unified_mem_arbiter_if.slave  bus
);

    state_t      r_state;
    owner_t      r_owner;
    logic        r_if_ack;
    logic        r_dm_ack;
    logic        r_dm_err;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    logic              w_grant_dm;
    logic              w_grant_if;
    logic              w_dm_bad;
    logic              w_start;
    logic [ADDR_W-3:0] w_base;
    logic              w_we;
    logic              w_last;
    logic [31:0]       w_word;
    logic              w_valid;
    logic              w_unused_addr;

    assign w_grant_dm = bus.dm_req & (~bus.if_req | DATA_FIRST);
    assign w_grant_if = bus.if_req & ~w_grant_dm;
    assign w_dm_bad   = w_grant_dm & is_misaligned(bus.dm_addr[1:0]);
    assign w_start    = (r_state == ST_IDLE) & (w_grant_if | (w_grant_dm & ~w_dm_bad));
    // Fetch address low bits are dropped, so a misaligned fetch reads its word
    assign w_base     = w_grant_dm ? bus.dm_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
    assign w_we       = w_grant_dm & bus.dm_we;

    assign w_unused_addr = ^{bus.if_addr[31:ADDR_W], bus.if_addr[1:0], bus.dm_addr[31:ADDR_W]};

    mem_beat_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .base      (w_base),
        .we        (w_we),
        .wdata     (bus.dm_wdata),
        .mem_en    (bus.mem_en),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata),
        .mem_rdata (bus.mem_rdata),
        .last      (w_last),
        .word      (w_word),
        .valid     (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_IF;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_dm_err   <= 1'b0;
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dm_bad) begin
                        r_owner  <= OWN_DM;
                        r_dm_ack <= 1'b1;
                        r_dm_err <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_start) begin
                        r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_last) begin
                        r_if_ack <= (r_owner == OWN_IF);
                        r_dm_ack <= (r_owner == OWN_DM);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Keep the delivered word so rdata holds after ack drops
                    if (w_valid) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= w_word;
                        end else begin
                            r_dm_rdata <= w_word;
                        end
                    end
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    r_dm_err <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.dm_err    = r_dm_err;
    assign bus.if_rdata  = (r_if_ack & w_valid) ? w_word : r_if_rdata;
    assign bus.dm_rdata  = (r_dm_ack & w_valid) ? w_word : r_dm_rdata;
    assign bus.cpu_stall = (bus.if_req & ~r_if_ack) | (bus.dm_req & ~r_dm_ack);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_unified_mem_arbiter : directed vectors and corner sequences for the arbiter
// Rev 1.0
// ============================================================================
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(5)) bus ();

    unified_mem_arbiter #(
        .ADDR_W     (5),
        .DATA_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] mem [32];
    logic       pl_we = 1'b0;
    logic [4:0] pl_addr = 5'd0;
    logic [7:0] pl_data = 8'h00;

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = a + 5'(i);
            pl_data = w[31-8*i -: 8];
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rdata;
        logic [31:0] exp_rdata;
        int          exp_ack;
        bit          exp_err;
        int          exp_we;
        int          exp_en;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input string tag);
        int          ack_at = -1;
        int          n_en = 0;
        int          n_we = 0;
        bit          stall_ok = 1'b1;
        logic [31:0] got_rd = 32'h0;
        logic        got_err = 1'b0;
        @(negedge clk);
        if (v.is_dm) begin
            bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.mem_en) n_en++;
            if (bus.mem_we) n_we++;
            if (v.is_dm ? bus.dm_ack : bus.if_ack) begin
                ack_at  = k;
                got_rd  = v.is_dm ? bus.dm_rdata : bus.if_rdata;
                got_err = bus.dm_err;
                break;
            end
            if (!bus.cpu_stall) stall_ok = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        check({tag, " ack_cycle"}, ack_at, v.exp_ack);
        check({tag, " err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        check({tag, " we_beats"}, n_we, v.exp_we);
        check({tag, " en_beats"}, n_en, v.exp_en);
        check({tag, " stall"}, {31'd0, stall_ok}, 32'd1);
        if (v.chk_rdata) check({tag, " rdata"}, got_rd, v.exp_rdata);
        @(negedge clk);
        check({tag, " ack_pulse"}, {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          dm_at;
        int          if_at;
        int          n_en;
        bit          stall_ok;
        logic [31:0] dm_rd;
        logic [31:0] if_rd;
        logic        dm_e;
        vec_t        v;

        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;

        vecs[0] = '{0, 0, 32'h00, 32'h0,        1, 32'h8C220010, 5, 0, 0, 4};
        vecs[1] = '{1, 1, 32'h08, 32'hDEADBEEF, 0, 32'h0,        5, 0, 4, 4};
        vecs[2] = '{1, 0, 32'h08, 32'h0,        1, 32'hDEADBEEF, 5, 0, 0, 4};
        vecs[3] = '{0, 0, 32'h23, 32'h0,        1, 32'h8C220010, 5, 0, 0, 4};
        vecs[4] = '{1, 0, 32'h10, 32'h0,        1, 32'h11223344, 5, 0, 0, 4};
        vecs[5] = '{1, 0, 32'h06, 32'h0,        1, 32'h11223344, 1, 1, 0, 0};
        vecs[6] = '{0, 0, 32'h48, 32'h0,        1, 32'hDEADBEEF, 5, 0, 0, 4};
        vecs[7] = '{1, 1, 32'h1C, 32'h01020304, 0, 32'h0,        5, 0, 4, 4};
        vecs[8] = '{1, 0, 32'h1C, 32'h0,        1, 32'h01020304, 5, 0, 0, 4};

        preload(5'd0,  32'h8C220010);
        preload(5'd8,  32'h00000000);
        preload(5'd16, 32'h11223344);
        preload(5'd28, 32'h00000000);

        @(negedge clk);
        check("rst if_ack",    {31'd0, bus.if_ack}, 32'd0);
        check("rst dm_ack",    {31'd0, bus.dm_ack}, 32'd0);
        check("rst dm_err",    {31'd0, bus.dm_err}, 32'd0);
        check("rst mem_en",    {31'd0, bus.mem_en}, 32'd0);
        check("rst if_rdata",  bus.if_rdata, 32'd0);
        check("rst dm_rdata",  bus.dm_rdata, 32'd0);
        check("rst cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("store bytes 8..11", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);

        // Both ports at once: data served first, fetch follows
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        dm_at = -1; if_at = -1; dm_rd = 0; if_rd = 0; stall_ok = 1'b1;
        #1 if (!bus.cpu_stall) stall_ok = 1'b0;
        for (int k = 1; k <= 30 && if_at < 0; k++) begin
            @(negedge clk);
            if (bus.dm_ack) begin dm_at = k; dm_rd = bus.dm_rdata; end
            if (bus.if_ack) begin if_at = k; if_rd = bus.if_rdata; end
            if (k <= 10 && !bus.cpu_stall) stall_ok = 1'b0;
            if (k == 11 && bus.cpu_stall) stall_ok = 1'b0;
            if (bus.dm_ack) bus.dm_req = 1'b0;
            if (bus.if_ack) bus.if_req = 1'b0;
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        check("both dm_ack_cycle", dm_at, 5);
        check("both if_ack_cycle", if_at, 11);
        check("both dm_rdata", dm_rd, 32'h11223344);
        check("both if_rdata", if_rd, 32'h8C220010);
        check("both stall_window", {31'd0, stall_ok}, 32'd1);

        // Misaligned load with a fetch pending
        @(negedge clk);
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h06;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        dm_at = -1; if_at = -1; n_en = 0; dm_e = 1'b0; if_rd = 0;
        for (int k = 1; k <= 30 && if_at < 0; k++) begin
            @(negedge clk);
            if (bus.mem_en) n_en++;
            if (bus.dm_ack) begin dm_at = k; dm_e = bus.dm_err; dm_rd = bus.dm_rdata; end
            if (bus.if_ack) begin if_at = k; if_rd = bus.if_rdata; end
            if (bus.dm_ack) bus.dm_req = 1'b0;
            if (bus.if_ack) bus.if_req = 1'b0;
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        check("mis dm_ack_cycle", dm_at, 1);
        check("mis dm_err", {31'd0, dm_e}, 32'd1);
        check("mis dm_rdata_hold", dm_rd, 32'h11223344);
        check("mis if_ack_cycle", if_at, 7);
        check("mis if_rdata", if_rd, 32'h11223344);
        check("mis en_beats", n_en, 4);

        // Reset lands after two store beats have been written
        @(negedge clk);
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0; bus.dm_wdata = 32'hA1B2C3D4;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid mem_en",   {31'd0, bus.mem_en}, 32'd0);
        check("rst_mid mem_we",   {31'd0, bus.mem_we}, 32'd0);
        check("rst_mid dm_ack",   {31'd0, bus.dm_ack}, 32'd0);
        check("rst_mid if_rdata", bus.if_rdata, 32'd0);
        check("rst_mid dm_rdata", bus.dm_rdata, 32'd0);
        bus.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid mem bytes", {mem[0], mem[1], mem[2], mem[3]}, 32'hA1B20010);
        v = '{0, 0, 32'h00, 32'h0, 1, 32'hA1B20010, 5, 0, 0, 4};
        run_vec(v, "post_rst_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
